// File: rtl/ad9226_multi_driver.sv
// Multi-channel AD9226 driver: one shared conversion clock, pipeline flush, per-channel averaging.
// Latency: one ad9226_clk period per sample; word valid 1 master_clock cycle after the final strobe of a window.
// Backpressure: single output word; a word completing while the output is held is dropped and counted.
module ad9226_multi_driver #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_LAT = 8,
  parameter int AVG_LOG2 = 0
) (
  input  logic                     master_clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] ad9226_data,
  input  logic [NUM_CH-1:0]        ad9226_otr,
  output logic                     ad9226_clk,
  output logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic [NUM_CH-1:0]        adc_otr,
  output logic                     adc_data_valid,
  input  logic                     adc_data_ready,
  output logic [NUM_CH-1:0]        otr_sticky,
  input  logic                     otr_clear,
  output logic [15:0]              overrun_count
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [3:0]       FLUSH_LAST = (PIPE_LAT > 0) ? 4'(PIPE_LAT - 1) : 4'd0;
  localparam logic [AVG_W-1:0] AVG_LAST   = AVG_W'((1 << AVG_LOG2) - 1);
  localparam logic [AVG_W-1:0] AVG_ONE    = AVG_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // registered copies of the ADC pins; nothing downstream looks at the raw pins
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic [NUM_CH-1:0]        otr_q;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             clk_nxt;

  logic [3:0] flush_cnt;

  logic [ACC_W-1:0] acc     [NUM_CH];
  logic [ACC_W-1:0] acc_sum [NUM_CH];
  logic [AVG_W-1:0] avg_cnt;
  logic [NUM_CH-1:0] win_otr;

  logic [NUM_CH*DATA_W-1:0] word_dat;
  logic [NUM_CH-1:0]        word_otr;

  logic strobe;
  logic flush_strobe;
  logic run_strobe;
  logic word_done;
  logic accept;

  assign accept = adc_data_valid && adc_data_ready;

  // capture ADC data and OTR pins one cycle before use
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      otr_q  <= '0;
    end else begin
      data_q <= ad9226_data;
      otr_q  <= ad9226_otr;
    end
  end

  // FSM state register
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: enable low always returns to IDLE from any active state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = (PIPE_LAT > 0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (flush_strobe && (flush_cnt == FLUSH_LAST)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the strobe falls one cycle ahead of each ad9226_clk rising edge
  always_comb begin
    strobe       = 1'b0;
    flush_strobe = 1'b0;
    run_strobe   = 1'b0;
    word_done    = 1'b0;
    strobe       = (state != IDLE) && enable && (div_cnt == DIV_LAST);
    flush_strobe = strobe && (state == FLUSH);
    run_strobe   = strobe && (state == RUN);
    word_done    = run_strobe && (avg_cnt == AVG_LAST);
  end

  // divider next value; it restarts at 0 on entry so the clock goes high with the first active cycle
  always_comb begin
    div_nxt = '0;
    clk_nxt = 1'b0;
    if ((state != IDLE) && (state_nxt != IDLE)) begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_ONE);
    end
    clk_nxt = (state_nxt != IDLE) && (div_nxt < DIV_HALF);
  end

  // divider counter and registered conversion clock
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      div_cnt    <= '0;
      ad9226_clk <= 1'b0;
    end else begin
      div_cnt    <= div_nxt;
      ad9226_clk <= clk_nxt;
    end
  end

  // count discarded samples while the ADC pipeline drains
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      flush_cnt <= '0;
    end else if (!enable || (state != FLUSH)) begin
      flush_cnt <= '0;
    end else if (flush_strobe) begin
      flush_cnt <= (flush_cnt == FLUSH_LAST) ? 4'd0 : (flush_cnt + 4'd1);
    end
  end

  // window sum including the current sample, and the word it would produce
  always_comb begin
    word_dat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      acc_sum[k] = acc[k] + ACC_W'(data_q[k*DATA_W +: DATA_W]);
      word_dat[k*DATA_W +: DATA_W] = acc_sum[k][AVG_LOG2 +: DATA_W];
    end
    word_otr = win_otr | otr_q;
  end

  // accumulate samples; the final strobe of a window restarts it so the next strobe begins a fresh one
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k] <= '0;
      end
      avg_cnt <= '0;
      win_otr <= '0;
    end else if (!enable || (state != RUN)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc[k] <= '0;
      end
      avg_cnt <= '0;
      win_otr <= '0;
    end else if (run_strobe) begin
      if (word_done) begin
        for (int k = 0; k < NUM_CH; k++) begin
          acc[k] <= '0;
        end
        avg_cnt <= '0;
        win_otr <= '0;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          acc[k] <= acc_sum[k];
        end
        avg_cnt <= avg_cnt + AVG_ONE;
        win_otr <= word_otr;
      end
    end
  end

  // output word register: load when empty or draining this cycle, otherwise hold and drop the new word
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      adc_data       <= '0;
      adc_otr        <= '0;
      adc_data_valid <= 1'b0;
    end else if (word_done && (!adc_data_valid || adc_data_ready)) begin
      adc_data       <= word_dat;
      adc_otr        <= word_otr;
      adc_data_valid <= 1'b1;
    end else if (accept) begin
      adc_data_valid <= 1'b0;
    end
  end

  // saturating count of words lost to a stalled consumer
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      overrun_count <= '0;
    end else if (word_done && adc_data_valid && !adc_data_ready && (overrun_count != 16'hFFFF)) begin
      overrun_count <= overrun_count + 16'd1;
    end
  end

  // sticky OTR per channel; a set in the same cycle as a clear survives
  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      otr_sticky <= '0;
    end else begin
      otr_sticky <= (otr_clear ? '0 : otr_sticky) | (run_strobe ? otr_q : '0);
    end
  end

endmodule
